// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline sequencing logic: FSM states,
// next-PC select encodings, reset PC and the default exception vector.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MDU_WAIT = 2'd1,
        EXC      = 2'd2
    } state_e;

    localparam logic [1:0]  NPC_SEQ   = 2'd0;
    localparam logic [1:0]  NPC_REDIR = 2'd1;
    localparam logic [1:0]  NPC_EXC   = 2'd2;

    localparam logic [31:0] EXC_VECTOR_DEF = 32'h0000_4180;
    localparam logic [31:0] RESET_PC       = 32'h0000_3000;

    // True when the ID instruction reads the register the EX instruction writes.
    function automatic logic src_match(
        input logic [4:0] rs,
        input logic [4:0] rt,
        input logic       use_rs,
        input logic       use_rt,
        input logic [4:0] rd
    );
        return (rd != 5'd0) && ((use_rs && rs == rd) || (use_rt && rt == rd));
    endfunction

endpackage

// File: rtl/mdu_busy_counter.sv
// Tracks how long the multiply/divide unit stays busy after a mult/div leaves EX.
// A load while already busy restarts the full latency.
module mdu_busy_counter
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned LATENCY = 5
) (
    input  logic clock,
    input  logic reset,
    input  logic load,
    output logic busy
);

    localparam logic [3:0] LAT = 4'(LATENCY);

    logic [3:0] cnt;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt <= 4'd0;
        end else if (load) begin
            cnt <= LAT;
        end else if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
        end
    end

    assign busy = (cnt != 4'd0);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller: resolves load-use, MDU-busy, EX redirect and
// MEM exception hazards into PC/latch enables, next-PC select and flushes.
module hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned MDU_LATENCY = 5,
    parameter logic [31:0] EXC_VECTOR  = EXC_VECTOR_DEF
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic        id_use_rs,
    input  logic        id_use_rt,
    input  logic        id_mdu_op,
    input  logic        ex_is_load,
    input  logic [4:0]  ex_rd,
    input  logic        ex_mdu_start,
    input  logic        ex_redirect,
    input  logic [31:0] ex_target,
    input  logic        exc_req,
    output logic        pc_we,
    output logic [1:0]  npc_sel,
    output logic [31:0] npc_target,
    output logic        ifid_we,
    output logic        ifid_flush,
    output logic        idex_flush,
    output logic        exmem_flush,
    output logic        mdu_busy,
    output logic [31:0] stall_cnt
);

    state_e state_q, state_d;
    logic   load_use, mdu_stall, exc_taken;

    assign load_use  = ex_is_load && src_match(id_rs, id_rt, id_use_rs, id_use_rt, ex_rd);
    assign mdu_stall = id_mdu_op && mdu_busy;
    // Masked in EXC so a still-asserted request cannot vector twice.
    assign exc_taken = exc_req && (state_q != EXC);

    // The EX instruction is flushed on an exception, so its mult/div never starts.
    mdu_busy_counter #(.LATENCY(MDU_LATENCY)) u_mdu_cnt (
        .clock (clock),
        .reset (reset),
        .load  (ex_mdu_start && !exc_taken),
        .busy  (mdu_busy)
    );

    always_comb begin
        state_d = RUN;
        if (exc_taken)      state_d = EXC;
        else if (mdu_stall) state_d = MDU_WAIT;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state_q <= RUN;
        else        state_q <= state_d;
    end

    always_comb begin
        pc_we       = 1'b1;
        ifid_we     = 1'b1;
        npc_sel     = NPC_SEQ;
        npc_target  = 32'd0;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        exmem_flush = 1'b0;
        if (!reset) begin
            pc_we       = 1'b0;
            ifid_we     = 1'b0;
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            exmem_flush = 1'b1;
        end else if (exc_taken) begin
            npc_sel     = NPC_EXC;
            npc_target  = EXC_VECTOR;
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            exmem_flush = 1'b1;
        end else if (ex_redirect) begin
            // ID holds a wrong-path instruction, so any stall on it is moot.
            npc_sel     = NPC_REDIR;
            npc_target  = ex_target;
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
        end else if (mdu_stall || load_use) begin
            pc_we       = 1'b0;
            ifid_we     = 1'b0;
            idex_flush  = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            stall_cnt <= 32'd0;
        end else if (!pc_we && stall_cnt != 32'hFFFF_FFFF) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: a table of single-cycle vectors from the RUN
// state, then hand sequences for MDU stalls, exception masking and reset.
module tb_hazard_ctrl;

    logic        clock = 1'b0;
    logic        reset;
    logic [4:0]  id_rs, id_rt, ex_rd;
    logic        id_use_rs, id_use_rt, id_mdu_op, ex_is_load;
    logic        ex_mdu_start, ex_redirect, exc_req;
    logic [31:0] ex_target;
    logic        pc_we, ifid_we, ifid_flush, idex_flush, exmem_flush, mdu_busy;
    logic [1:0]  npc_sel;
    logic [31:0] npc_target, stall_cnt;

    int n_vec = 0;
    int n_err = 0;
    int exp_stall = 0;

    always #5 clock = ~clock;

    hazard_ctrl dut (
        .clock        (clock),
        .reset        (reset),
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .id_use_rs    (id_use_rs),
        .id_use_rt    (id_use_rt),
        .id_mdu_op    (id_mdu_op),
        .ex_is_load   (ex_is_load),
        .ex_rd        (ex_rd),
        .ex_mdu_start (ex_mdu_start),
        .ex_redirect  (ex_redirect),
        .ex_target    (ex_target),
        .exc_req      (exc_req),
        .pc_we        (pc_we),
        .npc_sel      (npc_sel),
        .npc_target   (npc_target),
        .ifid_we      (ifid_we),
        .ifid_flush   (ifid_flush),
        .idex_flush   (idex_flush),
        .exmem_flush  (exmem_flush),
        .mdu_busy     (mdu_busy),
        .stall_cnt    (stall_cnt)
    );

    typedef struct {
        string       name;
        logic [4:0]  rs, rt;
        logic        use_rs, use_rt, is_load;
        logic [4:0]  rd;
        logic        redirect;
        logic [31:0] target;
        logic        exc;
        logic        e_pc_we, e_ifid_we;
        logic [1:0]  e_sel;
        logic [31:0] e_tgt;
        logic        e_iff, e_idf, e_exf;
    } vec_t;

    vec_t vt[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic chk_outs(input string name, input logic e_pc, input logic e_ifwe,
                            input logic [1:0] e_sel, input logic [31:0] e_tgt,
                            input logic e_iff, input logic e_idf, input logic e_exf);
        chk({name, ".pc_we"},       {31'd0, pc_we},       {31'd0, e_pc});
        chk({name, ".ifid_we"},     {31'd0, ifid_we},     {31'd0, e_ifwe});
        chk({name, ".npc_sel"},     {30'd0, npc_sel},     {30'd0, e_sel});
        chk({name, ".npc_target"},  npc_target,           e_tgt);
        chk({name, ".ifid_flush"},  {31'd0, ifid_flush},  {31'd0, e_iff});
        chk({name, ".idex_flush"},  {31'd0, idex_flush},  {31'd0, e_idf});
        chk({name, ".exmem_flush"}, {31'd0, exmem_flush}, {31'd0, e_exf});
    endtask

    task automatic idle();
        id_rs = 5'd0; id_rt = 5'd0; id_use_rs = 1'b0; id_use_rt = 1'b0;
        id_mdu_op = 1'b0; ex_is_load = 1'b0; ex_rd = 5'd0; ex_mdu_start = 1'b0;
        ex_redirect = 1'b0; ex_target = 32'd0; exc_req = 1'b0;
    endtask

    task automatic apply(input vec_t v);
        idle();
        id_rs = v.rs; id_rt = v.rt; id_use_rs = v.use_rs; id_use_rt = v.use_rt;
        ex_is_load = v.is_load; ex_rd = v.rd; ex_redirect = v.redirect;
        ex_target = v.target; exc_req = v.exc;
    endtask

    initial begin
        //          name        rs     rt     urs   urt   ld    rd     redir target        exc   pc    ifwe  sel   tgt           iff   idf   exf
        vt[0] = '{"idle",      5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 5'd0,  1'b0, 32'h0,        1'b0, 1'b1, 1'b1, 2'd0, 32'h0,        1'b0, 1'b0, 1'b0};
        vt[1] = '{"lu_rs",     5'd5,  5'd0,  1'b1, 1'b0, 1'b1, 5'd5,  1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 2'd0, 32'h0,        1'b0, 1'b1, 1'b0};
        vt[2] = '{"lu_r0",     5'd0,  5'd0,  1'b1, 1'b0, 1'b1, 5'd0,  1'b0, 32'h0,        1'b0, 1'b1, 1'b1, 2'd0, 32'h0,        1'b0, 1'b0, 1'b0};
        vt[3] = '{"lu_rt_nu",  5'd0,  5'd5,  1'b0, 1'b0, 1'b1, 5'd5,  1'b0, 32'h0,        1'b0, 1'b1, 1'b1, 2'd0, 32'h0,        1'b0, 1'b0, 1'b0};
        vt[4] = '{"lu_rt",     5'd3,  5'd7,  1'b1, 1'b1, 1'b1, 5'd7,  1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 2'd0, 32'h0,        1'b0, 1'b1, 1'b0};
        vt[5] = '{"lu_redir",  5'd5,  5'd0,  1'b1, 1'b0, 1'b1, 5'd5,  1'b1, 32'h0000_3040, 1'b0, 1'b1, 1'b1, 2'd1, 32'h0000_3040, 1'b1, 1'b1, 1'b0};
        vt[6] = '{"redir",     5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 5'd0,  1'b1, 32'h0000_3100, 1'b0, 1'b1, 1'b1, 2'd1, 32'h0000_3100, 1'b1, 1'b1, 1'b0};
        vt[7] = '{"exc_redir", 5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 5'd0,  1'b1, 32'h0000_3200, 1'b1, 1'b1, 1'b1, 2'd2, 32'h0000_4180, 1'b1, 1'b1, 1'b1};
        vt[8] = '{"exc_held",  5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 5'd0,  1'b0, 32'h0,        1'b1, 1'b1, 1'b1, 2'd0, 32'h0,        1'b0, 1'b0, 1'b0};
        vt[9] = '{"alu_dep",   5'd5,  5'd0,  1'b1, 1'b0, 1'b0, 5'd5,  1'b0, 32'h0,        1'b0, 1'b1, 1'b1, 2'd0, 32'h0,        1'b0, 1'b0, 1'b0};

        idle();
        reset = 1'b0;
        #2;
        chk_outs("rst", 1'b0, 1'b0, 2'd0, 32'h0, 1'b1, 1'b1, 1'b1);
        chk("rst.mdu_busy", {31'd0, mdu_busy}, 32'd0);
        chk("rst.stall_cnt", stall_cnt, 32'd0);
        @(negedge clock);
        reset = 1'b1;

        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            apply(vt[i]);
            #1;
            chk_outs(vt[i].name, vt[i].e_pc_we, vt[i].e_ifid_we, vt[i].e_sel, vt[i].e_tgt,
                     vt[i].e_iff, vt[i].e_idf, vt[i].e_exf);
            if (!vt[i].e_pc_we) exp_stall++;
            @(posedge clock);
            #1;
            chk({vt[i].name, ".stall_cnt"}, stall_cnt, 32'(exp_stall));
        end

        // MDU stall: mult leaves EX, then ID holds an MDU op for the full latency.
        @(negedge clock);
        idle();
        ex_mdu_start = 1'b1;
        #1;
        chk("mdu_start.busy", {31'd0, mdu_busy}, 32'd0);
        chk("mdu_start.pc_we", {31'd0, pc_we}, 32'd1);
        @(negedge clock);
        ex_mdu_start = 1'b0;
        id_mdu_op = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("mdu_wait", {29'd0, mdu_busy, pc_we, idex_flush}, {29'd0, 3'b101});
            exp_stall++;
            @(negedge clock);
        end
        #1;
        chk("mdu_done", {29'd0, mdu_busy, pc_we, ifid_we}, {29'd0, 3'b011});
        chk("mdu.stall_cnt", stall_cnt, 32'(exp_stall));

        // Restart while busy reloads the full latency.
        @(negedge clock);
        idle();
        ex_mdu_start = 1'b1;
        @(negedge clock);
        ex_mdu_start = 1'b0;
        @(negedge clock);
        @(negedge clock);
        ex_mdu_start = 1'b1;
        @(negedge clock);
        ex_mdu_start = 1'b0;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("mdu_reload.busy", {31'd0, mdu_busy}, 32'd1);
            @(negedge clock);
        end
        #1;
        chk("mdu_reload.idle", {31'd0, mdu_busy}, 32'd0);

        // Exception during an MDU stall with a redirect and a new mult in EX.
        @(negedge clock);
        idle();
        ex_mdu_start = 1'b1;
        @(negedge clock);
        ex_mdu_start = 1'b0;
        id_mdu_op = 1'b1;
        #1;
        chk("exc_pre.pc_we", {31'd0, pc_we}, 32'd0);
        exp_stall++;
        @(negedge clock);
        exc_req = 1'b1; ex_redirect = 1'b1; ex_target = 32'h0000_3040; ex_mdu_start = 1'b1;
        #1;
        chk_outs("exc_take", 1'b1, 1'b1, 2'd2, 32'h0000_4180, 1'b1, 1'b1, 1'b1);
        @(negedge clock);
        ex_redirect = 1'b0; ex_mdu_start = 1'b0; ex_target = 32'd0;
        #1;
        chk("exc_mask", {28'd0, npc_sel, exmem_flush, pc_we}, 32'd0);
        chk("exc_mask.busy", {31'd0, mdu_busy}, 32'd1);
        exp_stall++;
        @(negedge clock);
        exc_req = 1'b0;
        for (int k = 0; k < 2; k++) begin
            #1;
            chk("exc_drain", {30'd0, mdu_busy, pc_we}, {30'd0, 2'b10});
            exp_stall++;
            @(negedge clock);
        end
        #1;
        chk("exc_drain.done", {30'd0, mdu_busy, pc_we}, {30'd0, 2'b01});
        chk("exc.stall_cnt", stall_cnt, 32'(exp_stall));

        // Asynchronous reset in the middle of an MDU wait.
        @(negedge clock);
        idle();
        ex_mdu_start = 1'b1;
        @(negedge clock);
        ex_mdu_start = 1'b0;
        id_mdu_op = 1'b1;
        @(negedge clock);
        @(negedge clock);
        #1;
        reset = 1'b0;
        #1;
        chk_outs("rst_mid", 1'b0, 1'b0, 2'd0, 32'h0, 1'b1, 1'b1, 1'b1);
        chk("rst_mid.busy", {31'd0, mdu_busy}, 32'd0);
        chk("rst_mid.stall_cnt", stall_cnt, 32'd0);
        @(negedge clock);
        reset = 1'b1;
        #1;
        chk_outs("rst_rel", 1'b1, 1'b1, 2'd0, 32'h0, 1'b0, 1'b0, 1'b0);
        chk("rst_rel.busy", {31'd0, mdu_busy}, 32'd0);
        @(posedge clock);
        #1;
        chk("rst_rel.stall_cnt", stall_cnt, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline sequencing controller for the five-stage MIPS core. It drives the PC write enable and next-PC select, plus the IF/ID enable and the per-stage flushes. It resolves four hazard sources in one place:
- load-use stalls,
- multiply/divide-unit (MDU) busy stalls,
- EX-stage branch/jump redirects,
- MEM-stage exceptions.

It sits beside the PC register and pipeline latches; their enables come only from here.

## Interface
Parameters:
- MDU_LATENCY, 5, cycles the MDU stays busy after a mult/div leaves EX (1..15)
- EXC_VECTOR, 32'h0000_4180, exception handler address presented on npc_target

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- id_rs, id_rt  in  5 each  source registers of the instruction in ID
- id_use_rs, id_use_rt  in  1 each  ID instruction actually reads rs / rt
- id_mdu_op  in  1  ID instruction is mult/div/mfhi/mflo/mthi/mtlo
- ex_is_load  in  1  EX instruction is a load
- ex_rd  in  5  destination register of the EX instruction
- ex_mdu_start  in  1  EX instruction is mult/div
- ex_redirect  in  1  branch taken or jump resolved in EX
- ex_target  in  32  redirect address
- exc_req  in  1  exception raised in MEM
- pc_we  out  1  PC register write enable
- npc_sel  out  2  0 = sequential, 1 = redirect, 2 = exception
- npc_target  out  32  ex_target when npc_sel = 1, EXC_VECTOR when npc_sel = 2, else 0
- ifid_we  out  1  IF/ID latch enable
- ifid_flush, idex_flush, exmem_flush  out  1 each  insert a bubble into that latch
- mdu_busy  out  1  MDU counter non-zero
- stall_cnt  out  32  saturating count of cycles with pc_we = 0 outside reset

## Operation
- FSM states:
  - RUN: normal operation.
  - MDU_WAIT: an MDU stall is in progress.
  - EXC: the one cycle after an exception is taken.
- Load-use hazard:
  - Condition: ex_is_load && ex_rd != 0 && ((id_use_rs && id_rs == ex_rd) || (id_use_rt && id_rt == ex_rd)).
  - Response: pc_we = 0, ifid_we = 0, idex_flush = 1.
- MDU counter:
  - Loads MDU_LATENCY when ex_mdu_start is accepted.
  - Otherwise decrements while non-zero.
  - mdu_busy = (counter != 0).
  - MDU stall = id_mdu_op && mdu_busy. It has the same response as load-use.
  - FSM is in MDU_WAIT while the MDU stall holds, and returns to RUN on the first cycle it drops.
- Redirect, ex_redirect = 1:
  - Outputs: pc_we = 1, npc_sel = 1, ifid_flush = 1, idex_flush = 1.
  - Overrides both stalls, because the ID instruction is on the wrong path.
- Exception, exc_req = 1 in RUN or MDU_WAIT:
  - Outputs: pc_we = 1, npc_sel = 2, ifid_flush = idex_flush = exmem_flush = 1.
  - FSM goes to EXC.
  - ex_mdu_start is ignored that cycle, since the EX instruction is flushed.
- EXC state:
  - exc_req is masked, so no duplicate vectoring occurs.
  - Otherwise behaves as RUN.
  - Returns to RUN next cycle.
- Priority: exception > redirect > MDU stall > load-use > sequential.
- Default outputs: pc_we = 1, ifid_we = 1, npc_sel = 0, all flushes 0.
- The MDU counter keeps running through exceptions and redirects, so HI/LO completes.
- stall_cnt increments on every cycle with pc_we = 0 while reset is high, and holds at 32'hFFFF_FFFF.

## Timing
- All control outputs are combinational from registered state/counter and current inputs. They are sampled by the PC register and latches on the same rising edge (zero-cycle latency).
- FSM, MDU counter and stall_cnt update on the rising edge.
- While reset = 0:
  - FSM = RUN, counter = 0, stall_cnt = 0.
  - pc_we = 0, ifid_we = 0, npc_sel = 0, npc_target = 0, all flushes = 1, mdu_busy = 0.
- Reset asserted mid-stall or mid-EXC clears the state immediately (asynchronous). The first cycle after release is RUN with default outputs.
- A load-use stall lasts exactly 1 cycle: the load moves to MEM and the condition clears.
- An MDU stall lasts until the counter reaches 0. With ex_mdu_start at edge t, mdu_busy is high for MDU_LATENCY cycles.
- ex_mdu_start while already busy reloads the counter to MDU_LATENCY.

## Structure
- Shared package pipe_ctrl_pkg holds:
  - state enum {RUN, MDU_WAIT, EXC};
  - npc_sel encodings NPC_SEQ/NPC_REDIR/NPC_EXC;
  - EXC_VECTOR default;
  - RESET_PC 32'h0000_3000.
- One sub-module, mdu_busy_counter: a 4-bit load/decrement counter producing mdu_busy.
- Hazard decode and FSM live in hazard_ctrl.

## Test plan
- Load r5 in EX, ID reads rs = 5 with id_use_rs = 1 -> exactly 1 cycle of pc_we = 0, ifid_we = 0, idex_flush = 1; stall_cnt = 1. Repeat with ex_rd = 0 -> no stall.
- ex_mdu_start, then id_mdu_op held -> mdu_busy high 5 cycles, pc_we low for those 5 cycles, then FSM returns to RUN; stall_cnt = 5.
- Load-use and ex_redirect (ex_target = 32'h0000_3040) together -> pc_we = 1, npc_sel = 1, npc_target = 32'h0000_3040, ifid_flush = idex_flush = 1, no stall.
- exc_req with ex_redirect and MDU stall active:
  - that cycle: npc_sel = 2, npc_target = 32'h0000_4180, all three flushes = 1;
  - exc_req held next cycle -> ignored (npc_sel = 0);
  - mdu_busy keeps counting down.
- Reset asserted during MDU_WAIT (counter = 3) -> all outputs at reset values immediately; after release, mdu_busy = 0, FSM in RUN, stall_cnt = 0.
